// File: rtl/ebpc_dec_out_packer_if.sv
// rtl/ebpc_dec_out_packer_if.sv - decoded word input and packed beat output bundle
// Optional EBPC_DEC_OUT_PACKER_STALL_CNT_EN adds stall_cnt_o.
interface ebpc_dec_out_packer_if #(
    parameter int DATA_W = 8,
    parameter int PACK_N = 4,
    parameter int CNT_W  = 24
);
    logic [DATA_W-1:0]        data_i;
    logic                     vld_i;
    logic                     last_i;
    logic                     rdy_o;
    logic [PACK_N*DATA_W-1:0] data_o;
    logic [PACK_N-1:0]        strb_o;
    logic                     last_o;
    logic                     vld_o;
    logic                     rdy_i;
    logic [CNT_W-1:0]         cnt_o;
`ifdef EBPC_DEC_OUT_PACKER_STALL_CNT_EN
    logic [31:0]              stall_cnt_o;

    modport slave (
        input  data_i, vld_i, last_i, rdy_i,
        output rdy_o, data_o, strb_o, last_o, vld_o, cnt_o, stall_cnt_o
    );
    modport master (
        output data_i, vld_i, last_i, rdy_i,
        input  rdy_o, data_o, strb_o, last_o, vld_o, cnt_o, stall_cnt_o
    );
`else
    modport slave (
        input  data_i, vld_i, last_i, rdy_i,
        output rdy_o, data_o, strb_o, last_o, vld_o, cnt_o
    );
    modport master (
        output data_i, vld_i, last_i, rdy_i,
        input  rdy_o, data_o, strb_o, last_o, vld_o, cnt_o
    );
`endif
endinterface

// File: rtl/ebpc_dec_out_packer.sv
// rtl/ebpc_dec_out_packer.sv - packs PACK_N decoded words per beat, flushes with strobes on last
// Optional EBPC_DEC_OUT_PACKER_STALL_CNT_EN adds a saturating output stall counter.
module ebpc_dec_out_packer #(
    parameter int DATA_W = 8,
    parameter int PACK_N = 4,
    parameter int CNT_W  = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    ebpc_dec_out_packer_if.slave  bus
);
    localparam int IDX_W  = $clog2(PACK_N);
    localparam int BEAT_W = PACK_N * DATA_W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACK_N - 1);

    logic [IDX_W-1:0]  idx_q;
    logic [BEAT_W-1:0] pack_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [BEAT_W-1:0] data_q;
    logic [PACK_N-1:0] strb_q;
    logic              last_q;
    logic              vld_q;
    logic [CNT_W-1:0]  cnt_out_q;

    logic              completes;
    logic              rdy;
    logic              in_fire;
    logic              out_fire;
    logic [CNT_W-1:0]  cnt_next;
    logic [BEAT_W-1:0] pack_merged;
    logic [PACK_N-1:0] strb_next;

    always_comb begin
        completes = (idx_q == IDX_LAST) || bus.last_i;
        // A non-completing word only touches the pack register, so it never waits on the output slot.
        rdy       = !completes || !vld_q || bus.rdy_i;
        in_fire   = bus.vld_i && rdy;
        out_fire  = vld_q && bus.rdy_i;
        cnt_next  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

        pack_merged = pack_q;
        strb_next   = '0;
        for (int k = 0; k < PACK_N; k++) begin
            if (idx_q == IDX_W'(k)) begin
                pack_merged[k*DATA_W +: DATA_W] = bus.data_i;
            end
            strb_next[k] = (IDX_W'(k) <= idx_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q     <= '0;
            pack_q    <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            last_q    <= 1'b0;
            vld_q     <= 1'b0;
            cnt_out_q <= '0;
        end else begin
            if (in_fire) begin
                if (completes) begin
                    data_q    <= pack_merged;
                    strb_q    <= strb_next;
                    last_q    <= bus.last_i;
                    cnt_out_q <= cnt_next;
                    idx_q     <= '0;
                    pack_q    <= '0;
                    cnt_q     <= bus.last_i ? '0 : cnt_next;
                end else begin
                    pack_q <= pack_merged;
                    idx_q  <= idx_q + 1'b1;
                    cnt_q  <= cnt_next;
                end
            end
            if (in_fire && completes) begin
                vld_q <= 1'b1;
            end else if (out_fire) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign bus.rdy_o  = rdy;
    assign bus.data_o = data_q;
    assign bus.strb_o = strb_q;
    assign bus.last_o = last_q;
    assign bus.vld_o  = vld_q;
    assign bus.cnt_o  = cnt_out_q;

`ifdef EBPC_DEC_OUT_PACKER_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (vld_q && !bus.rdy_i && !(&stall_q)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.stall_cnt_o = stall_q;
`endif
endmodule

// File: tb/tb_ebpc_dec_out_packer.sv
// tb/tb_ebpc_dec_out_packer.sv - scoreboard bench for ebpc_dec_out_packer (PACK_N=4, DATA_W=8)
module tb_ebpc_dec_out_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ebpc_dec_out_packer_if #(.DATA_W(8), .PACK_N(4), .CNT_W(24)) bus ();

    ebpc_dec_out_packer #(.DATA_W(8), .PACK_N(4), .CNT_W(24)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic [23:0] cnt;
    } beat_t;

    beat_t sb[$];
    int    errors = 0;
    int    checks = 0;
    int    beats = 0;
    int    vld_cycles = 0;
    int    last_wait = 0;
    int    waits[12];
    int    stall_left = 0;
    bit    stall_arm = 1'b0;
    bit    prev_stall = 1'b0;
    beat_t held;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic [3:0] s, input logic l, input logic [23:0] c);
        beat_t b;
        b.data = d; b.strb = s; b.last = l; b.cnt = c;
        sb.push_back(b);
    endtask

    // Called at posedge+1; returns at posedge+1 after the word transfers.
    task automatic send(input logic [7:0] d, input logic l);
        int w;
        w = 0;
        bus.data_i = d;
        bus.last_i = l;
        bus.vld_i  = 1'b1;
        @(negedge clk);
        while (!bus.rdy_o && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (w >= 100) check("send_timeout", 64'(w), 64'(0));
        @(posedge clk);
        #1;
        bus.vld_i  = 1'b0;
        bus.last_i = 1'b0;
        last_wait  = w;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain_empty", 64'(sb.size()), 64'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on each accepted beat and checks hold stability under stall.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.vld_o) vld_cycles++;
            if (prev_stall) begin
                check("hold_data", 64'(bus.data_o), 64'(held.data));
                check("hold_strb", 64'(bus.strb_o), 64'(held.strb));
                check("hold_last", 64'(bus.last_o), 64'(held.last));
                check("hold_cnt",  64'(bus.cnt_o),  64'(held.cnt));
            end
            prev_stall = bus.vld_o && !bus.rdy_i;
            held.data = bus.data_o; held.strb = bus.strb_o;
            held.last = bus.last_o; held.cnt  = bus.cnt_o;
            if (bus.vld_o && bus.rdy_i) begin
                beat_t e;
                beats++;
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'(bus.data_o), 64'hDEAD_0000_0000);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", 64'(bus.data_o), 64'(e.data));
                    check("beat_strb", 64'(bus.strb_o), 64'(e.strb));
                    check("beat_last", 64'(bus.last_o), 64'(e.last));
                    check("beat_cnt",  64'(bus.cnt_o),  64'(e.cnt));
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Output backpressure: once armed, hold rdy_i low for 5 cycles from the first vld_o.
    always @(posedge clk) begin
        #1;
        if (stall_arm && bus.vld_o) begin
            stall_arm  = 1'b0;
            bus.rdy_i  = 1'b0;
            stall_left = 5;
        end else if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) bus.rdy_i = 1'b1;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, 64'(bus.data_o), 64'(0));
        check({tag, "_strb"}, 64'(bus.strb_o), 64'(0));
        check({tag, "_last"}, 64'(bus.last_o), 64'(0));
        check({tag, "_vld"},  64'(bus.vld_o),  64'(0));
        check({tag, "_cnt"},  64'(bus.cnt_o),  64'(0));
        check({tag, "_rdy"},  64'(bus.rdy_o),  64'(1));
    endtask

    initial begin
        int base;
        int wsum;
        bus.data_i = '0;
        bus.vld_i  = 1'b0;
        bus.last_i = 1'b0;
        bus.rdy_i  = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: one full packet in a single beat
        base = beats; vld_cycles = 0;
        expect_beat(32'h44332211, 4'hF, 1'b1, 24'd4);
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
        @(negedge clk);
        check("t1_latency_vld", 64'(bus.vld_o), 64'(1));
        check("t1_latency_data", 64'(bus.data_o), 64'h44332211);
        drain();
        check("t1_vld_cycles", 64'(vld_cycles), 64'(1));
        check("t1_beats", 64'(beats - base), 64'(1));

        // 2: six words -> full beat plus partial flush
        base = beats;
        expect_beat(32'h04030201, 4'hF, 1'b0, 24'd4);
        expect_beat(32'h00000605, 4'h3, 1'b1, 24'd6);
        for (int i = 1; i <= 6; i++) send(8'(i), i == 6);
        drain();
        check("t2_beats", 64'(beats - base), 64'(2));

        // 3: single-word packet
        base = beats;
        expect_beat(32'h000000AB, 4'h1, 1'b1, 24'd1);
        send(8'hAB, 1'b1);
        drain();
        check("t3_beats", 64'(beats - base), 64'(1));

        // 4: twelve streamed words under a 5-cycle output stall
        base = beats;
        expect_beat(32'h03020100, 4'hF, 1'b0, 24'd4);
        expect_beat(32'h07060504, 4'hF, 1'b0, 24'd8);
        expect_beat(32'h0B0A0908, 4'hF, 1'b1, 24'd12);
        stall_arm = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(8'(i), i == 11);
            waits[i] = last_wait;
        end
        drain();
        for (int i = 0; i < 7; i++) check($sformatf("t4_wait%0d", i), 64'(waits[i]), 64'(0));
        check("t4_rdy_drop_on_beat2", 64'(waits[7] != 0), 64'(1));
        check("t4_beats", 64'(beats - base), 64'(3));
`ifdef EBPC_DEC_OUT_PACKER_STALL_CNT_EN
        check("t4_stall_cnt", 64'(bus.stall_cnt_o), 64'(5));
`endif

        // 5: reset mid-packet discards partial words
        base = beats;
        send(8'h11, 1'b0); send(8'h22, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("t5_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_beat(32'hEFBEADDE, 4'hF, 1'b1, 24'd4);
        send(8'hDE, 1'b0); send(8'hAD, 1'b0); send(8'hBE, 1'b0); send(8'hEF, 1'b1);
        drain();
        check("t5_beats", 64'(beats - base), 64'(1));

        // 6: 1024 words back-to-back
        base = beats; wsum = 0;
        for (int b = 0; b < 256; b++) begin
            logic [7:0] w0;
            w0 = 8'(4 * b);
            expect_beat({w0 + 8'd3, w0 + 8'd2, w0 + 8'd1, w0}, 4'hF, b == 255, 24'(4 * (b + 1)));
        end
        for (int i = 0; i < 1024; i++) begin
            send(8'(i), i == 1023);
            wsum += last_wait;
        end
        drain();
        check("t6_rdy_never_low", 64'(wsum), 64'(0));
        check("t6_beats", 64'(beats - base), 64'(256));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
